// File: rtl/led_status_pkg.sv
// Shared types and constants for the status-LED controller.
// Config word layout: [31:16] period, [15:8] duty, [7:3] rsvd, [2:0] mode.
package led_status_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_PWM   = 3'd3,
    MODE_HB    = 3'd4
  } led_mode_t;

  // Bit offsets: period 16, duty 8, rsvd 3, mode 0.
  typedef struct packed {
    logic [15:0] period;
    logic [7:0]  duty;
    logic [4:0]  rsvd;
    logic [2:0]  mode;
  } led_cfg_t;

  localparam logic [15:0] HB_ON0_END        = 16'd100;
  localparam logic [15:0] HB_ON1_START      = 16'd200;
  localparam logic [15:0] HB_ON1_END        = 16'd300;
  localparam logic [15:0] HB_MIN_PERIOD     = 16'd400;
  localparam logic [15:0] HB_DEFAULT_PERIOD = 16'd1000;

endpackage

// File: rtl/led_status_chan.sv
// One LED channel: ms_cnt, phase and the combinational on-decision.
// Ports: clk_50, fpga_reset_n, tick, clr (config write), mode/period/duty, pwm_cnt -> on.
// Macro LED_STATUS_GAMMA_EN selects a squared PWM compare value.
module led_status_chan
  import led_status_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_50,
  input  logic                fpga_reset_n,
  input  logic                tick,
  input  logic                clr,
  input  logic [2:0]          mode,
  input  logic [15:0]         period,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                on
);

  logic [15:0]         ms_cnt;
  logic                phase;
  logic [15:0]         blink_last;
  logic [15:0]         hb_last;
  logic [PWM_BITS-1:0] cmp;

  assign blink_last = (period == '0) ? '0 : period - 16'd1;
  assign hb_last    = (period < HB_MIN_PERIOD) ?
                      HB_DEFAULT_PERIOD - 16'd1 :
                      period - 16'd1;

`ifdef LED_STATUS_GAMMA_EN
  logic [2*PWM_BITS-1:0] dx;
  assign dx  = {{PWM_BITS{1'b0}}, duty};
  // Full scale stays full scale so max duty is still ~100%.
  assign cmp = (duty == '1) ? '1 :
               PWM_BITS'((dx * dx) >> PWM_BITS);
`else
  assign cmp = duty;
`endif

  // A config write beats a coincident tick: counter restarts at 0.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      ms_cnt <= '0;
      phase  <= 1'b0;
    end else if (clr) begin
      ms_cnt <= '0;
      phase  <= 1'b1;
    end else begin
      case (mode)
        MODE_BLINK: begin
          if (tick) begin
            if (ms_cnt >= blink_last) begin
              ms_cnt <= '0;
              phase  <= ~phase;
            end else begin
              ms_cnt <= ms_cnt + 16'd1;
            end
          end
        end
        MODE_HB: begin
          if (tick) begin
            if (ms_cnt >= hb_last) ms_cnt <= '0;
            else ms_cnt <= ms_cnt + 16'd1;
          end
        end
        default: ms_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    on = 1'b0;
    case (mode)
      MODE_ON:    on = 1'b1;
      MODE_BLINK: on = phase;
      MODE_PWM:   on = (pwm_cnt < cmp);
      MODE_HB:    on = (ms_cnt < HB_ON0_END) ||
                       ((ms_cnt >= HB_ON1_START) &&
                        (ms_cnt < HB_ON1_END));
      default:    on = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_ctrl.sv
// N-channel status-LED controller: prescaler, PWM counter, config regs, readback.
// Ports: clk_50, fpga_reset_n, cfg_wr/rd/addr/wdata -> cfg_rdata, tick_out, led_out.
// Macro LED_STATUS_GAMMA_EN (in led_status_chan) enables gamma-corrected PWM.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int NUM_LEDS       = 5,
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1000,
  parameter int PWM_BITS       = 8,
  parameter int HB_CH          = 4,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic                clk_50,
  input  logic                fpga_reset_n,
  input  logic                cfg_wr,
  input  logic                cfg_rd,
  input  logic [3:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  output logic                tick_out,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int   DIV = CLK_HZ / TICK_HZ;
  localparam int   PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic POL = (LED_ACTIVE_LOW != 0);

  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  led_cfg_t            cfg_q [NUM_LEDS];
  led_cfg_t            rd_val;
  logic [NUM_LEDS-1:0] wr_hit;
  logic [NUM_LEDS-1:0] on_vec;

  assign tick_out = (presc == PSW'(DIV - 1));

  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick_out ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_comb begin
    wr_hit = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      wr_hit[i] = cfg_wr && (cfg_addr == 4'(i));
      if (cfg_addr == 4'(i)) rd_val = cfg_q[i];
    end
  end

  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (i == HB_CH)
          cfg_q[i] <= '{period: HB_DEFAULT_PERIOD,
                        duty:   '0,
                        rsvd:   '0,
                        mode:   MODE_HB};
        else
          cfg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        if (wr_hit[i]) cfg_q[i] <= cfg_wdata;
    end
  end

  // rd_val is taken before the write lands: same-cycle read sees old data.
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) cfg_rdata <= '0;
    else if (cfg_rd)   cfg_rdata <= rd_val;
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    led_status_chan #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk_50      (clk_50),
      .fpga_reset_n(fpga_reset_n),
      .tick        (tick_out),
      .clr         (wr_hit[g]),
      .mode        (cfg_q[g].mode),
      .period      (cfg_q[g].period),
      .duty        (cfg_q[g].duty[PWM_BITS-1:0]),
      .pwm_cnt     (pwm_cnt),
      .on          (on_vec[g])
    );
  end

  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) led_out <= {NUM_LEDS{POL}};
    else               led_out <= on_vec ^ {NUM_LEDS{POL}};
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (1 tick = 50 clocks).
// Runs an active-high and an active-low instance on shared inputs.
module tb_led_status_ctrl;

  logic        clk_50 = 1'b0;
  logic        fpga_reset_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic        cfg_rd = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata, cfg_rdata_n;
  logic        tick_out, tick_n;
  logic [4:0]  led_out, led_out_n;

  int n_checks = 0;
  int n_errors = 0;
  bit samp [0:600];
  bit samp_n [0:600];

  always #5 clk_50 = ~clk_50;

  led_status_ctrl #(
    .NUM_LEDS(5), .CLK_HZ(50000), .TICK_HZ(1000)
  ) dut (
    .clk_50(clk_50), .fpga_reset_n(fpga_reset_n),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .tick_out(tick_out),
    .led_out(led_out)
  );

  led_status_ctrl #(
    .NUM_LEDS(5), .CLK_HZ(50000), .TICK_HZ(1000),
    .LED_ACTIVE_LOW(1)
  ) dut_n (
    .clk_50(clk_50), .fpga_reset_n(fpga_reset_n),
    .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata_n), .tick_out(tick_n),
    .led_out(led_out_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_50);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a,
                    output logic [31:0] d);
    cfg_rd = 1'b1;
    cfg_addr = a;
    step();
    cfg_rd = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic wait_tick;
    int n = 0;
    while (!tick_out && n < 100) begin
      step();
      n++;
    end
    if (!tick_out) chk("tick_wait", 32'd0, 32'd1);
  endtask

  task automatic capture(input int ch, input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      samp[k] = led_out[ch];
      samp_n[k] = led_out_n[ch];
    end
  endtask

  function automatic int count_hi(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) c += int'(samp[k]);
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int hb_k [9] = '{1, 5000, 5001, 10000, 10001,
                     15000, 15001, 50000, 50001};
    bit hb_e [9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    int hi, ticks;
    bit low_bad;

    repeat (3) step();
    chk("rst_led", 32'(led_out), 32'h00);
    chk("rst_led_n", 32'(led_out_n), 32'h1f);
    chk("rst_rdata", cfg_rdata, 32'h0);
    chk("rst_tick", 32'(tick_out), 32'h0);
    fpga_reset_n = 1'b1;

    hi = 0;
    ticks = 0;
    low_bad = 1'b0;
    for (int k = 1; k <= 50001; k++) begin
      step();
      if (k <= 50000) begin
        hi += int'(led_out[4]);
        ticks += int'(tick_out);
      end
      if (led_out[3:0] != 4'h0) low_bad = 1'b1;
      for (int j = 0; j < 9; j++)
        if (k == hb_k[j])
          chk($sformatf("hb_k%0d", k),
              32'(led_out[4]), 32'(hb_e[j]));
      if (k == 1) chk("hb_pol_n", 32'(led_out_n), 32'h0f);
      if (k == 48) chk("tick_48", 32'(tick_out), 32'd0);
      if (k == 49) chk("tick_49", 32'(tick_out), 32'd1);
      if (k == 49) chk("tick_n_49", 32'(tick_n), 32'd1);
      if (k == 50) chk("tick_50", 32'(tick_out), 32'd0);
    end
    chk("hb_hi_cycles", 32'(hi), 32'd10000);
    chk("hb_ticks", 32'(ticks), 32'd1000);
    chk("hb_low_ch_off", 32'(low_bad), 32'd0);

    wait_tick();
    wr(4'd0, 32'h0003_0002);
    capture(0, 301);
    chk("blk3_1", 32'(samp[1]), 32'd1);
    chk("blk3_150", 32'(samp[150]), 32'd1);
    chk("blk3_151", 32'(samp[151]), 32'd0);
    chk("blk3_300", 32'(samp[300]), 32'd0);
    chk("blk3_301", 32'(samp[301]), 32'd1);
    chk("blk3_hi", 32'(count_hi(300)), 32'd150);
    chk("blk3_n_1", 32'(samp_n[1]), 32'd0);

    wait_tick();
    wr(4'd0, 32'h0000_0002);
    capture(0, 101);
    chk("blk0_50", 32'(samp[50]), 32'd1);
    chk("blk0_51", 32'(samp[51]), 32'd0);
    chk("blk0_100", 32'(samp[100]), 32'd0);
    chk("blk0_101", 32'(samp[101]), 32'd1);

    wr(4'd1, 32'h0000_4003);
    step();
    capture(1, 256);
    chk("pwm_64", 32'(count_hi(256)), 32'd64);
    wr(4'd1, 32'h0000_0003);
    step();
    capture(1, 256);
    chk("pwm_0", 32'(count_hi(256)), 32'd0);
    wr(4'd1, 32'h0000_ff03);
    step();
    capture(1, 256);
    chk("pwm_255", 32'(count_hi(256)), 32'd255);
    wr(4'd1, 32'h0000_8003);
    step();
    capture(1, 256);
`ifdef LED_STATUS_GAMMA_EN
    chk("pwm_128_gamma", 32'(count_hi(256)), 32'd64);
`else
    chk("pwm_128", 32'(count_hi(256)), 32'd128);
`endif
    rd(4'd1, d);
    chk("rd_duty_raw", d, 32'h0000_8003);

    wait_tick();
    wr(4'd2, 32'h0000_0001);
    chk("on_edge1", 32'(led_out[2]), 32'd0);
    step();
    chk("on_edge2", 32'(led_out[2]), 32'd1);
    chk("on_edge2_n", 32'(led_out_n[2]), 32'd0);

    wr(4'd7, 32'hffff_ffff);
    rd(4'd7, d);
    chk("rd_oob", d, 32'h0);
    rd(4'd3, d);
    chk("oob_ch3", d, 32'h0);
    rd(4'd0, d);
    chk("oob_ch0", d, 32'h0000_0002);
    rd(4'd2, d);
    chk("oob_ch2", d, 32'h0000_0001);

    wr(4'd3, 32'h0000_0005);
    rd(4'd3, d);
    chk("mode5_rd", d, 32'h0000_0005);
    step();
    chk("mode5_off", 32'(led_out[3]), 32'd0);

    cfg_rd = 1'b1;
    cfg_wr = 1'b1;
    cfg_addr = 4'd4;
    cfg_wdata = 32'h0000_0001;
    step();
    cfg_rd = 1'b0;
    cfg_wr = 1'b0;
    chk("rw_old", cfg_rdata, 32'h03e8_0004);
    step();
    step();
    chk("rd_hold", cfg_rdata, 32'h03e8_0004);
    rd(4'd4, d);
    chk("rw_new", d, 32'h0000_0001);

    wait_tick();
    wr(4'd0, 32'h0003_0002);
    repeat (10) step();
    chk("pre_rst_led0", 32'(led_out[0]), 32'd1);
    chk("pre_rst_led0_n", 32'(led_out_n[0]), 32'd0);
    fpga_reset_n = 1'b0;
    #1;
    chk("async_led", 32'(led_out), 32'h00);
    chk("async_led_n", 32'(led_out_n), 32'h1f);
    chk("async_rdata", cfg_rdata, 32'h0);
    chk("async_rdata_n", cfg_rdata_n, 32'h0);
    step();
    fpga_reset_n = 1'b1;
    rd(4'd4, d);
    chk("rst_hb_cfg", d, 32'h03e8_0004);
    rd(4'd0, d);
    chk("rst_ch0_cfg", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
